sram_obi_bridge: RTL and testbench
==================================

Name: sram_obi_bridge

Overview:
- Manager-side bridge: converts a simple SRAM-style requester port (req/gnt, rvalid/rdata) into an OBI manager port.
- Lets SRAM-style masters (DMA engines, simple cores, test generators) reach an OBI crossbar or OBI subordinates.
- Registers the address phase so the OBI stability rule holds.
- Bounds outstanding transactions with a credit counter.

Parameters:
- ObiCfg, obi_pkg::ObiDefaultConfig, OBI configuration of the manager port.
- obi_req_t, logic, OBI request struct.
- obi_rsp_t, logic, OBI response struct.
- MaxTrans, 2, max transactions accepted on the SRAM side and not yet answered; legal range 1..16.
- Id, 0, constant aid driven on every OBI request; width ObiCfg.IdWidth.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  1  SRAM-side request.
- we_i  in  1  write enable.
- addr_i  in  ObiCfg.AddrWidth  byte address.
- wdata_i  in  ObiCfg.DataWidth  write data.
- be_i  in  ObiCfg.DataWidth/8  byte enables.
- gnt_o  out  1  request accepted this cycle.
- rvalid_o  out  1  response valid.
- rdata_o  out  ObiCfg.DataWidth  read data.
- err_o  out  1  response error (OBI err or ID mismatch).
- obi_req_o  out  obi_req_t  OBI manager request.
- obi_rsp_i  in  obi_rsp_t  OBI manager response.

Behaviour:
- Elaboration checks:
  - $fatal if ObiCfg.OptionalCfg.UseAtop or ObiCfg.Integrity.
  - $fatal if MaxTrans is outside 1..16.
- Hold register:
  - Contents: hold_valid_q plus we/addr/wdata/be.
  - obi_req_o.req = hold_valid_q.
  - obi_req_o.a fields come only from the hold register.
  - aid = Id; atop and a_optional = '0.
  - rready = 1 when ObiCfg.UseRReady.
- Handshakes:
  - obi_hs = hold_valid_q & obi_rsp_i.gnt.
  - rsp_hs = obi_rsp_i.rvalid & (cnt_q != 0).
- Credit counter: cnt_q, width $clog2(MaxTrans+1). It counts transactions that have been accepted on the SRAM side and not yet responded, including the one in the hold register.
- gnt_o = (!hold_valid_q | obi_hs) & ((cnt_q < MaxTrans) | rsp_hs).
  - gnt_o is purely combinational and does not depend on req_i.
- Accept: when req_i & gnt_o, the hold register loads the inputs and hold_valid_d = 1.
- No accept:
  - If obi_hs, hold_valid_d = 0.
  - Otherwise the hold register is unchanged. This guarantees OBI address-phase stability until gnt.
- Back-to-back:
  - An accept and obi_hs in the same cycle replace the held entry.
  - Sustained throughput is 1 transaction/cycle when the subordinate grants every cycle and MaxTrans ≥ 2 for 1-cycle-latency subordinates.
- Latency:
  - SRAM accept at cycle N → OBI req at N+1.
  - Response is forwarded in the same cycle it arrives.
- cnt_d = cnt_q + (req_i & gnt_o) − rsp_hs. It never exceeds MaxTrans and never underflows.
- Response path (combinational, in order):
  - rvalid_o = rsp_hs.
  - rdata_o = obi_rsp_i.r.rdata.
  - err_o = rsp_hs & (obi_rsp_i.r.err | (obi_rsp_i.r.rid != Id)).
- Spurious response: obi rvalid with cnt_q == 0 is dropped (rvalid_o = 0) and flagged by a simulation assertion.
- Simultaneous accept and response at cnt_q == MaxTrans: grant is allowed and the count stays at MaxTrans.
- Reset (async, rst_ni low):
  - hold_valid_q = 0, hold data = '0, cnt_q = 0.
  - Therefore obi_req_o.req = 0, rvalid_o = 0, err_o = 0.
  - gnt_o = 1 after reset.
  - Reset mid-transaction discards held and outstanding transactions. Late responses after reset are treated as spurious.
- Assertions:
  - obi_req_o.a is stable while req & !gnt.
  - cnt_q ≤ MaxTrans.

Decomposition:
- No new package: obi_pkg already provides obi_cfg_t and the defaults.
- Counter width is a localparam.
- No sub-module. The hold register is simple enough to stay inline; a generic spill register would lose the combinational-release gnt.

Test Plan:
- Single read:
  - Stimulus: req_i=1, we=0, addr=0x100 at cycle 0; subordinate grants at cycle 1 and returns rdata=0xDEADBEEF, rid=Id at cycle 2.
  - Required: gnt_o=1 at cycle 0; obi req at cycle 1; rvalid_o=1, rdata_o=0xDEADBEEF, err_o=0 at cycle 2.
- Stall stability:
  - Stimulus: write addr=0x40, wdata=0x12345678, be=0xF; subordinate holds gnt=0 for 4 cycles.
  - Required: OBI a-fields unchanged throughout; gnt_o=0 to a second request until the OBI gnt.
- Credit limit:
  - Stimulus: MaxTrans=2, subordinate grants but delays rvalid 5 cycles.
  - Required: third request sees gnt_o=0 until the first rvalid; in that cycle gnt_o=1 and cnt stays 2.
- Throughput:
  - Stimulus: 8 back-to-back reads to a 1-cycle subordinate that always grants, MaxTrans=2.
  - Required: 8 grants in 8 consecutive cycles; responses in order.
- Errors:
  - Stimulus: one response with err=1, then one with rid=Id+1.
  - Required: err_o=1 on both; a spurious rvalid with cnt=0 gives rvalid_o=0.
- Reset mid-operation:
  - Stimulus: assert rst_ni=0 with 1 held and 1 outstanding transaction.
  - Required: obi req=0 immediately (async); cnt=0; gnt_o=1 after release.

Source files
------------

// File: rtl/obi_pkg.sv
// OBI configuration type, default configuration and default request/response
// structs for a 32-bit address/data manager port.
package obi_pkg;

    typedef struct packed {
        logic UseAtop;
        logic UseProt;
    } obi_optional_cfg_t;

    typedef struct packed {
        logic              UseRReady;
        logic              CombGnt;
        int unsigned       AddrWidth;
        int unsigned       DataWidth;
        int unsigned       IdWidth;
        logic              Integrity;
        obi_optional_cfg_t OptionalCfg;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{
        UseRReady:   1'b0,
        CombGnt:     1'b0,
        AddrWidth:   32,
        DataWidth:   32,
        IdWidth:     1,
        Integrity:   1'b0,
        OptionalCfg: '{UseAtop: 1'b0, UseProt: 1'b0}
    };

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [0:0]  aid;
        logic [5:0]  atop;
        logic        a_optional;
    } obi_default_a_chan_t;

    typedef struct packed {
        logic                req;
        logic                rready;
        obi_default_a_chan_t a;
    } obi_default_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [0:0]  rid;
        logic        err;
        logic        r_optional;
    } obi_default_r_chan_t;

    typedef struct packed {
        logic                gnt;
        logic                rvalid;
        obi_default_r_chan_t r;
    } obi_default_rsp_t;

endpackage

// File: rtl/sram_obi_bridge.sv
// SRAM-style req/gnt requester to OBI manager bridge: registered address phase,
// combinationally forwarded responses, credit-limited outstanding transactions.
module sram_obi_bridge
    import obi_pkg::*;
#(
    parameter obi_cfg_t    ObiCfg    = ObiDefaultConfig,
    parameter type         obi_req_t = obi_default_req_t,
    parameter type         obi_rsp_t = obi_default_rsp_t,
    parameter int unsigned MaxTrans  = 2,
    parameter logic [ObiCfg.IdWidth-1:0] Id = '0
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          req_i,
    input  logic                          we_i,
    input  logic [ObiCfg.AddrWidth-1:0]   addr_i,
    input  logic [ObiCfg.DataWidth-1:0]   wdata_i,
    input  logic [ObiCfg.DataWidth/8-1:0] be_i,
    output logic                          gnt_o,
    output logic                          rvalid_o,
    output logic [ObiCfg.DataWidth-1:0]   rdata_o,
    output logic                          err_o,
    output obi_req_t                      obi_req_o,
    input  obi_rsp_t                      obi_rsp_i
);

    localparam int unsigned CntW = $clog2(MaxTrans + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxTrans);

    if (ObiCfg.OptionalCfg.UseAtop || ObiCfg.Integrity) begin : gen_cfg_check
        $fatal(1, "sram_obi_bridge: atomics and integrity are not supported");
    end
    if (MaxTrans < 1 || MaxTrans > 16) begin : gen_max_trans_check
        $fatal(1, "sram_obi_bridge: MaxTrans must be within 1..16");
    end

    typedef struct packed {
        logic                          we;
        logic [ObiCfg.AddrWidth-1:0]   addr;
        logic [ObiCfg.DataWidth-1:0]   wdata;
        logic [ObiCfg.DataWidth/8-1:0] be;
    } hold_t;

    hold_t           hold_q, hold_d;
    logic            hold_valid_q, hold_valid_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            obi_hs, rsp_hs, accept;
    logic            unused_rsp;

    always_comb begin
        obi_hs = hold_valid_q & obi_rsp_i.gnt;
        rsp_hs = obi_rsp_i.rvalid & (cnt_q != '0);
        // A slot frees up either when the held entry is granted this cycle or
        // when a response retires a credit this very cycle.
        gnt_o  = (!hold_valid_q | obi_hs) & ((cnt_q < MaxCnt) | rsp_hs);
        accept = req_i & gnt_o;

        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        if (accept) begin
            hold_valid_d = 1'b1;
            hold_d       = '{we: we_i, addr: addr_i, wdata: wdata_i, be: be_i};
        end else if (obi_hs) begin
            hold_valid_d = 1'b0;
        end

        cnt_d = cnt_q + CntW'(accept) - CntW'(rsp_hs);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_valid_q <= 1'b0;
            hold_q       <= '0;
            cnt_q        <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_q       <= hold_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        obi_req_o              = '0;
        obi_req_o.req          = hold_valid_q;
        obi_req_o.rready       = ObiCfg.UseRReady;
        obi_req_o.a.addr       = hold_q.addr;
        obi_req_o.a.we         = hold_q.we;
        obi_req_o.a.be         = hold_q.be;
        obi_req_o.a.wdata      = hold_q.wdata;
        obi_req_o.a.aid        = Id;
        obi_req_o.a.atop       = '0;
        obi_req_o.a.a_optional = '0;
    end

    always_comb begin
        rvalid_o = rsp_hs;
        rdata_o  = obi_rsp_i.r.rdata;
        err_o    = rsp_hs & (obi_rsp_i.r.err | (obi_rsp_i.r.rid != Id));
    end

    assign unused_rsp = ^obi_rsp_i;

`ifndef SYNTHESIS
    a_addr_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (obi_req_o.req && !obi_rsp_i.gnt) |=> (obi_req_o.req && $stable(obi_req_o.a)))
        else $error("sram_obi_bridge: OBI address phase changed before gnt");
    a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni) cnt_q <= MaxCnt)
        else $error("sram_obi_bridge: credit counter above MaxTrans");
    // Responses without an outstanding transaction are dropped, only reported.
    a_spurious_rsp: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(obi_rsp_i.rvalid && cnt_q == '0))
        else $warning("sram_obi_bridge: spurious OBI response dropped");
`endif

endmodule

// File: tb/tb_sram_obi_bridge.sv
// Bench for sram_obi_bridge: directed scenarios plus randomized traffic
// against a transaction-level reference model and an OBI subordinate model.
module tb_sram_obi_bridge;
    import obi_pkg::*;

    localparam int unsigned MAX_TRANS = 2;
    localparam logic [0:0]  ID        = 1'b0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } txn_t;

    typedef struct {
        logic        is_read;
        logic [31:0] data;
    } exp_rsp_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } sub_rsp_t;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [3:0]  be_i = '0;
    logic        gnt_o, rvalid_o, err_o;
    logic [31:0] rdata_o;
    obi_default_req_t obi_req;
    obi_default_rsp_t obi_rsp = '0;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sram_obi_bridge #(
        .ObiCfg   (ObiDefaultConfig),
        .obi_req_t(obi_default_req_t),
        .obi_rsp_t(obi_default_rsp_t),
        .MaxTrans (MAX_TRANS),
        .Id       (ID)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .req_i    (req_i),
        .we_i     (we_i),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .be_i     (be_i),
        .gnt_o    (gnt_o),
        .rvalid_o (rvalid_o),
        .rdata_o  (rdata_o),
        .err_o    (err_o),
        .obi_req_o(obi_req),
        .obi_rsp_i(obi_rsp)
    );

    task automatic next_cycle();
        @(negedge clk);
        req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; be_i = '0;
        obi_rsp = '0;
    endtask

    task automatic test_reset();
        next_cycle();
        #1;
        n_checks++; if (obi_req.req !== 1'b0) begin n_fail++; $display("FAIL rst_in_req: got %b want 0", obi_req.req); end
        n_checks++; if (rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rst_in_rvalid: got %b want 0", rvalid_o); end
        next_cycle();
        rst_ni = 1'b1;
        #1;
        n_checks++; if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL rst_gnt: got %b want 1", gnt_o); end
        n_checks++; if (obi_req.req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", obi_req.req); end
        n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err_o); end
        $display("test_reset done");
    endtask

    task automatic test_single_read();
        next_cycle();
        req_i = 1'b1; addr_i = 32'h100; be_i = 4'hF;
        #1;
        n_checks++; if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL rd_gnt: got %b want 1", gnt_o); end
        next_cycle();
        obi_rsp.gnt = 1'b1;
        #1;
        n_checks++; if (obi_req.req !== 1'b1) begin n_fail++; $display("FAIL rd_obi_req: got %b want 1", obi_req.req); end
        n_checks++; if (obi_req.a.addr !== 32'h100 || obi_req.a.we !== 1'b0) begin n_fail++; $display("FAIL rd_obi_a: got addr %h we %b want 100/0", obi_req.a.addr, obi_req.a.we); end
        next_cycle();
        obi_rsp.rvalid = 1'b1; obi_rsp.r.rdata = 32'hDEADBEEF; obi_rsp.r.rid = ID;
        #1;
        n_checks++; if (rvalid_o !== 1'b1) begin n_fail++; $display("FAIL rd_rvalid: got %b want 1", rvalid_o); end
        n_checks++; if (rdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_rdata: got %h want deadbeef", rdata_o); end
        n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL rd_err: got %b want 0", err_o); end
        next_cycle();
        #1;
        n_checks++; if (obi_req.req !== 1'b0 || gnt_o !== 1'b1) begin n_fail++; $display("FAIL rd_idle: got req %b gnt %b want 0/1", obi_req.req, gnt_o); end
        $display("test_single_read done");
    endtask

    task automatic test_stall_stability();
        next_cycle();
        req_i = 1'b1; we_i = 1'b1; addr_i = 32'h40; wdata_i = 32'h12345678; be_i = 4'hF;
        #1;
        n_checks++; if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL stall_gnt0: got %b want 1", gnt_o); end
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            req_i = 1'b1; addr_i = 32'h44; be_i = 4'hF;
            obi_rsp.gnt = (c == 4);
            #1;
            n_checks++;
            if (obi_req.req !== 1'b1 || obi_req.a.addr !== 32'h40 || obi_req.a.wdata !== 32'h12345678
                || obi_req.a.we !== 1'b1 || obi_req.a.be !== 4'hF) begin
                n_fail++; $display("FAIL stall_a c%0d: got req %b addr %h wdata %h we %b be %h", c,
                                   obi_req.req, obi_req.a.addr, obi_req.a.wdata, obi_req.a.we, obi_req.a.be);
            end
            n_checks++; if (gnt_o !== (c == 4)) begin n_fail++; $display("FAIL stall_gnt c%0d: got %b want %b", c, gnt_o, (c == 4)); end
        end
        next_cycle();
        obi_rsp.gnt = 1'b1; obi_rsp.rvalid = 1'b1; obi_rsp.r.rid = ID;
        #1;
        n_checks++; if (obi_req.a.addr !== 32'h44 || obi_req.a.we !== 1'b0) begin n_fail++; $display("FAIL stall_second: got addr %h we %b want 44/0", obi_req.a.addr, obi_req.a.we); end
        n_checks++; if (rvalid_o !== 1'b1) begin n_fail++; $display("FAIL stall_rsp1: got %b want 1", rvalid_o); end
        next_cycle();
        obi_rsp.rvalid = 1'b1; obi_rsp.r.rid = ID;
        #1;
        n_checks++; if (rvalid_o !== 1'b1) begin n_fail++; $display("FAIL stall_rsp2: got %b want 1", rvalid_o); end
        next_cycle();
        #1;
        n_checks++; if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL stall_idle_gnt: got %b want 1", gnt_o); end
        $display("test_stall_stability done");
    endtask

    task automatic test_credit_limit();
        for (int c = 0; c < 11; c++) begin
            next_cycle();
            if (c <= 6) begin req_i = 1'b1; addr_i = 32'h400 + 32'(4 * ((c > 2) ? 2 : c)); be_i = 4'hF; end
            obi_rsp.gnt = (c >= 1 && c <= 7);
            obi_rsp.rvalid = (c == 6 || c == 8 || c == 9);
            obi_rsp.r.rid = ID;
            #1;
            if (c <= 1 || c == 6 || c >= 8) begin
                n_checks++; if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL credit_gnt c%0d: got %b want 1", c, gnt_o); end
            end else begin
                n_checks++; if (gnt_o !== 1'b0) begin n_fail++; $display("FAIL credit_block c%0d: got %b want 0", c, gnt_o); end
            end
            if (c == 6 || c == 8 || c == 9) begin
                n_checks++; if (rvalid_o !== 1'b1) begin n_fail++; $display("FAIL credit_rvalid c%0d: got %b want 1", c, rvalid_o); end
            end
            if (c == 7) begin
                n_checks++; if (obi_req.req !== 1'b1 || obi_req.a.addr !== 32'h408) begin n_fail++; $display("FAIL credit_third: got req %b addr %h want 1/408", obi_req.req, obi_req.a.addr); end
            end
        end
        $display("test_credit_limit done");
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q[$];
        logic [31:0] exp_d;
        logic        pend_v = 1'b0;
        logic [31:0] pend_d = '0;
        int          grants = 0;
        int          resps = 0;
        for (int i = 0; i < 12; i++) begin
            next_cycle();
            req_i = (i < 8); addr_i = 32'h200 + 32'(4 * i); be_i = 4'hF;
            obi_rsp.gnt = 1'b1; obi_rsp.rvalid = pend_v; obi_rsp.r.rdata = pend_d; obi_rsp.r.rid = ID;
            #1;
            if (i < 8) begin
                n_checks++; if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt i%0d: got %b want 1", i, gnt_o); end
                if (gnt_o === 1'b1) grants++;
                exp_q.push_back(32'hA5A50000 ^ addr_i);
            end
            if (rvalid_o === 1'b1) begin
                resps++;
                exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hX;
                n_checks++; if (rdata_o !== exp_d) begin n_fail++; $display("FAIL b2b_rdata r%0d: got %h want %h", resps, rdata_o, exp_d); end
            end
            pend_v = obi_req.req;
            pend_d = 32'hA5A50000 ^ obi_req.a.addr;
        end
        n_checks++; if (grants != 8) begin n_fail++; $display("FAIL b2b_grants: got %0d want 8", grants); end
        n_checks++; if (resps != 8) begin n_fail++; $display("FAIL b2b_resps: got %0d want 8", resps); end
        $display("test_back_to_back done: %0d grants %0d responses", grants, resps);
    endtask

    task automatic test_errors();
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            req_i = 1'b1; addr_i = 32'h300; be_i = 4'hF;
            next_cycle();
            obi_rsp.gnt = 1'b1;
            next_cycle();
            obi_rsp.rvalid = 1'b1;
            obi_rsp.r.err = (k == 0);
            obi_rsp.r.rid = (k == 0) ? ID : ID + 1'b1;
            #1;
            n_checks++; if (rvalid_o !== 1'b1 || err_o !== 1'b1) begin n_fail++; $display("FAIL err_rsp k%0d: got rvalid %b err %b want 1/1", k, rvalid_o, err_o); end
        end
        next_cycle();
        obi_rsp.rvalid = 1'b1; obi_rsp.r.rid = ID; obi_rsp.r.err = 1'b1;
        #1;
        n_checks++; if (rvalid_o !== 1'b0 || err_o !== 1'b0) begin n_fail++; $display("FAIL err_spurious: got rvalid %b err %b want 0/0", rvalid_o, err_o); end
        $display("test_errors done");
    endtask

    task automatic test_random_traffic();
        txn_t        hold_q[$];
        exp_rsp_t    exp_q[$];
        sub_rsp_t    sub_q[$];
        txn_t        t;
        sub_rsp_t    s;
        exp_rsp_t    e;
        logic [31:0] ref_mem[16];
        logic [31:0] sub_mem[16];
        int          outstanding = 0;
        int          cyc = 0;
        int          n_txn = 0;
        logic        exp_gnt, rsp_this;
        logic [3:0]  idx;
        for (int i = 0; i < 16; i++) begin ref_mem[i] = '0; sub_mem[i] = '0; end
        while (cyc < 400 || hold_q.size() > 0 || outstanding > 0) begin
            if (cyc > 1200) begin
                n_checks++; n_fail++;
                $display("FAIL rnd_drain: %0d outstanding after %0d cycles want 0", outstanding, cyc);
                break;
            end
            next_cycle();
            req_i   = (cyc < 400) && ($urandom_range(0, 9) < 6);
            we_i    = 1'($urandom);
            addr_i  = {26'b0, 4'($urandom_range(0, 15)), 2'b00};
            wdata_i = $urandom;
            be_i    = 4'($urandom);
            obi_rsp.gnt = ($urandom_range(0, 9) < 7);
            obi_rsp.r.rdata = $urandom;
            if (sub_q.size() > 0 && sub_q[0].due <= cyc && $urandom_range(0, 9) < 8) begin
                obi_rsp.rvalid  = 1'b1;
                obi_rsp.r.rdata = sub_q[0].rdata;
                obi_rsp.r.err   = sub_q[0].err;
                obi_rsp.r.rid   = ID;
            end
            rsp_this = obi_rsp.rvalid && outstanding > 0;
            exp_gnt  = (hold_q.size() == 0 || obi_rsp.gnt) && (outstanding < MAX_TRANS || rsp_this);
            #1;
            n_checks++; if (gnt_o !== exp_gnt) begin n_fail++; $display("FAIL rnd_gnt cyc%0d: got %b want %b", cyc, gnt_o, exp_gnt); end
            n_checks++; if (obi_req.req !== (hold_q.size() > 0)) begin n_fail++; $display("FAIL rnd_req cyc%0d: got %b want %b", cyc, obi_req.req, hold_q.size() > 0); end
            if (hold_q.size() > 0) begin
                n_checks++;
                if (obi_req.a.addr !== hold_q[0].addr || obi_req.a.we !== hold_q[0].we || obi_req.a.aid !== ID
                    || obi_req.a.be !== hold_q[0].be || obi_req.a.wdata !== hold_q[0].wdata) begin
                    n_fail++; $display("FAIL rnd_a cyc%0d: got addr %h we %b be %h wdata %h want %h %b %h %h", cyc,
                        obi_req.a.addr, obi_req.a.we, obi_req.a.be, obi_req.a.wdata,
                        hold_q[0].addr, hold_q[0].we, hold_q[0].be, hold_q[0].wdata);
                end
            end
            n_checks++; if (rvalid_o !== rsp_this) begin n_fail++; $display("FAIL rnd_rvalid cyc%0d: got %b want %b", cyc, rvalid_o, rsp_this); end
            if (rsp_this) begin
                n_checks++; if (err_o !== obi_rsp.r.err) begin n_fail++; $display("FAIL rnd_err cyc%0d: got %b want %b", cyc, err_o, obi_rsp.r.err); end
                if (exp_q.size() > 0 && exp_q[0].is_read) begin
                    n_checks++; if (rdata_o !== exp_q[0].data) begin n_fail++; $display("FAIL rnd_rdata cyc%0d: got %h want %h", cyc, rdata_o, exp_q[0].data); end
                end
            end
            if (hold_q.size() > 0 && obi_rsp.gnt) begin
                idx = obi_req.a.addr[5:2];
                s.rdata = obi_req.a.we ? 32'h0 : sub_mem[idx];
                if (obi_req.a.we) for (int b = 0; b < 4; b++) if (obi_req.a.be[b]) sub_mem[idx][8*b +: 8] = obi_req.a.wdata[8*b +: 8];
                s.err = ($urandom_range(0, 19) == 0);
                s.due = cyc + 1 + int'($urandom_range(0, 3));
                sub_q.push_back(s);
                void'(hold_q.pop_front());
            end
            if (rsp_this) begin
                if (sub_q.size() > 0) void'(sub_q.pop_front());
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                outstanding--;
            end
            if (req_i && exp_gnt) begin
                t = '{we: we_i, addr: addr_i, wdata: wdata_i, be: be_i};
                hold_q.push_back(t);
                idx = addr_i[5:2];
                e.is_read = !we_i;
                e.data = ref_mem[idx];
                if (we_i) for (int b = 0; b < 4; b++) if (be_i[b]) ref_mem[idx][8*b +: 8] = wdata_i[8*b +: 8];
                exp_q.push_back(e);
                outstanding++;
                n_txn++;
            end
            cyc++;
        end
        $display("test_random_traffic done: %0d transactions in %0d cycles", n_txn, cyc);
    endtask

    task automatic test_reset_mid();
        next_cycle();
        req_i = 1'b1; addr_i = 32'h500; be_i = 4'hF;
        #1;
        n_checks++; if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL rmid_gnt_a: got %b want 1", gnt_o); end
        next_cycle();
        req_i = 1'b1; addr_i = 32'h504; be_i = 4'hF; obi_rsp.gnt = 1'b1;
        #1;
        n_checks++; if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL rmid_gnt_b: got %b want 1", gnt_o); end
        next_cycle();
        #1;
        n_checks++; if (obi_req.req !== 1'b1) begin n_fail++; $display("FAIL rmid_held: got %b want 1", obi_req.req); end
        #2;
        rst_ni = 1'b0;
        #1;
        n_checks++; if (obi_req.req !== 1'b0) begin n_fail++; $display("FAIL rmid_async_req: got %b want 0", obi_req.req); end
        next_cycle();
        rst_ni = 1'b1;
        #1;
        n_checks++; if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL rmid_gnt_after: got %b want 1", gnt_o); end
        next_cycle();
        obi_rsp.rvalid = 1'b1; obi_rsp.r.rid = ID; obi_rsp.r.rdata = 32'hCAFE0000;
        #1;
        n_checks++; if (rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rmid_late_rsp: got %b want 0", rvalid_o); end
        next_cycle();
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_stall_stability();
        test_credit_limit();
        test_back_to_back();
        test_errors();
        test_random_traffic();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
